// File: rtl/requant_sparse_out.sv
// requant_sparse_out: requantizes INT32 result blocks to INT8 rows with a ready/valid stream.
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   in_valid/in_ready  block handshake; in_data [row][col] partial sums, in_block_row/col indices
//   scale_mult, scale_shift, zero_point  requant config, sampled on block accept
//   out_valid/out_ready row handshake; out_data INT8 row, out_row/out_col indices, out_last on final row
//   busy, blocks_done, sat_count  status
// Build option: define REQUANT_RELU_EN to clamp negative shifted values to 0 before the zero-point add.
module requant_sparse_out #(
  parameter int PE_ROWS   = 2,
  parameter int BLOCK_W   = 8,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid,
  input  logic [PE_ROWS-1:0][BLOCK_W-1:0][ACC_WIDTH-1:0]   in_data,
  input  logic [15:0]                                      in_block_row,
  input  logic [15:0]                                      in_block_col,
  output logic                                             in_ready,
  input  logic signed [15:0]                               scale_mult,
  input  logic [4:0]                                       scale_shift,
  input  logic signed [7:0]                                zero_point,
  output logic                                             out_valid,
  output logic [BLOCK_W-1:0][OUT_WIDTH-1:0]                out_data,
  output logic [15:0]                                      out_row,
  output logic [15:0]                                      out_col,
  output logic                                             out_last,
  input  logic                                             out_ready,
  output logic                                             busy,
  output logic [31:0]                                      blocks_done,
  output logic [31:0]                                      sat_count
);
  localparam int RW = PE_ROWS > 1 ? $clog2(PE_ROWS) : 1;
  localparam int PW = ACC_WIDTH + 16;
  localparam int EW = PW + 1;
  localparam logic signed [EW-1:0] MAXV = (EW'(1) <<< (OUT_WIDTH - 1)) - EW'(1);
  localparam logic signed [EW-1:0] MINV = -MAXV - EW'(1);
  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;
  state_t state, state_n;
  logic [PE_ROWS-1:0][BLOCK_W-1:0][ACC_WIDTH-1:0] data_q;
  logic [15:0] brow_q, bcol_q;
  logic signed [15:0] mult_q;
  logic [4:0] shift_q;
  logic signed [7:0] zp_q;
  logic [RW-1:0] row_sel;
  logic signed [PW-1:0] prod [BLOCK_W];
  logic signed [EW-1:0] rnd [BLOCK_W];
  logic signed [EW-1:0] shf [BLOCK_W];
  logic signed [EW-1:0] val [BLOCK_W];
  logic [BLOCK_W-1:0] sat;
  logic [BLOCK_W-1:0][OUT_WIDTH-1:0] q;
  logic [32:0] sat_sum;
  logic accept, fire, last;
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign last      = row_sel == RW'(PE_ROWS - 1);
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign out_valid = state == EMIT;
  assign out_last  = out_valid && last;
  assign out_data  = out_valid ? q : '0;
  assign out_row   = brow_q * 16'(PE_ROWS) + 16'(row_sel);
  assign out_col   = bcol_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? CALC : IDLE)
            : state == CALC ? EMIT
            : fire ? (last ? IDLE : CALC) : EMIT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_q      <= '0;
      brow_q      <= '0;
      bcol_q      <= '0;
      mult_q      <= '0;
      shift_q     <= '0;
      zp_q        <= '0;
      row_sel     <= '0;
      blocks_done <= '0;
      sat_count   <= '0;
    end else begin
      if (accept) begin
        data_q  <= in_data;
        brow_q  <= in_block_row;
        bcol_q  <= in_block_col;
        mult_q  <= scale_mult;
        shift_q <= scale_shift;
        zp_q    <= zero_point;
        row_sel <= '0;
      end
      if (fire) begin
        row_sel   <= last ? '0 : row_sel + RW'(1);
        sat_count <= sat_sum[32] ? '1 : sat_sum[31:0];
        if (last) blocks_done <= blocks_done + 32'd1;
      end
    end
  // Full-width products so no precision is lost before rounding.
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int c = 0; c < BLOCK_W; c++) prod[c] <= '0;
    else if (state == CALC)
      for (int c = 0; c < BLOCK_W; c++)
        prod[c] <= PW'($signed(data_q[row_sel][c])) * PW'(mult_q);
  // Round half up, shift, offset, saturate; sat_sum is the post-handshake saturating count.
  always_comb begin
    sat_sum = {1'b0, sat_count};
    for (int c = 0; c < BLOCK_W; c++) begin
      rnd[c] = EW'(prod[c]) + ((shift_q == 5'd0) ? EW'(0) : (EW'(1) <<< (shift_q - 5'd1)));
      shf[c] = rnd[c] >>> shift_q;
`ifdef REQUANT_RELU_EN
      if (shf[c] < 0) shf[c] = '0;
`endif
      val[c] = shf[c] + EW'(zp_q);
      sat[c] = val[c] > MAXV || val[c] < MINV;
      q[c] = val[c] > MAXV ? OUT_WIDTH'(MAXV) : val[c] < MINV ? OUT_WIDTH'(MINV) : val[c][OUT_WIDTH-1:0];
      sat_sum = sat_sum + 33'(sat[c]);
    end
  end
endmodule

// File: tb/tb_requant_sparse_out.sv
// tb_requant_sparse_out: randomized self-checking bench for requant_sparse_out against an arithmetic model.
module tb_requant_sparse_out;
  logic clk = 0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_last, out_ready, busy;
  logic [1:0][7:0][31:0] in_data;
  logic [15:0] in_block_row, in_block_col, out_row, out_col;
  logic signed [15:0] scale_mult;
  logic [4:0] scale_shift;
  logic signed [7:0] zero_point;
  logic [7:0][7:0] out_data;
  logic [31:0] blocks_done, sat_count;
  int vectors = 0;
  int errors = 0;
  longint blocks_exp = 0;
  longint sat_exp = 0;
  logic [1:0][7:0][31:0] blk;

  requant_sparse_out dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_block_row(in_block_row), .in_block_col(in_block_col), .in_ready(in_ready),
    .scale_mult(scale_mult), .scale_shift(scale_shift), .zero_point(zero_point),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .out_ready(out_ready), .busy(busy),
    .blocks_done(blocks_done), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void ref_elem(input logic signed [31:0] a, input logic signed [15:0] m,
                                   input int sh, input logic signed [7:0] zp,
                                   output logic [7:0] q, output bit s);
    longint p;
    p = longint'(a) * longint'(m);
    if (sh > 0) p = p + (longint'(1) <<< (sh - 1));
    p = p >>> sh;
`ifdef REQUANT_RELU_EN
    if (p < 0) p = 0;
`endif
    p = p + longint'(zp);
    s = p > 127 || p < -128;
    q = p > 127 ? 8'd127 : p < -128 ? 8'h80 : 8'(p);
  endfunction

  function automatic logic [31:0] rnd_acc();
    return ($urandom % 2) ? 32'(int'($urandom_range(0, 4000)) - 2000) : 32'($urandom);
  endfunction

  function automatic logic [1:0][7:0][31:0] rnd_blk();
    logic [1:0][7:0][31:0] b;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++) b[r][c] = rnd_acc();
    return b;
  endfunction

  task automatic run_block(input logic [1:0][7:0][31:0] d, input logic [15:0] br, input logic [15:0] bc,
                           input logic signed [15:0] m, input logic [4:0] sh,
                           input logic signed [7:0] zp, input bit stall);
    int waited, lat, r, stall_left, ns;
    logic [7:0] q;
    bit s;
    @(negedge clk);
    in_data = d; in_block_row = br; in_block_col = bc;
    scale_mult = m; scale_shift = sh; zero_point = zp; in_valid = 1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", waited, 0);
    @(posedge clk);
    #1;
    in_valid = 0;
    scale_mult = (m == 16'sd1) ? 16'sd7 : 16'($urandom);
    scale_shift = 5'($urandom);
    zero_point = 8'($urandom);
    in_data = rnd_blk();
    lat = 0; r = 0; stall_left = stall ? 5 : 0;
    while (r < 2 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (r == 0 && lat <= 2) check("latency", out_valid, lat == 2);
      if (out_valid) begin
        out_ready = stall_left > 0 ? 1'b0 : 1'($urandom % 4 != 0);
        if (stall_left > 0) stall_left--;
        check("in_ready_busy", in_ready, 0);
        check("busy", busy, 1);
        ns = 0;
        for (int c = 0; c < 8; c++) begin
          ref_elem(d[r][c], m, int'(sh), zp, q, s);
          check("data", $signed(out_data[c]), $signed(q));
          ns += int'(s);
        end
        check("row", out_row, longint'(br) * 2 + r);
        check("col", out_col, bc);
        check("last", out_last, r == 1);
        if (out_ready) begin
          sat_exp += ns;
          r++;
        end
        in_valid = (r == 2) ? 1'b0 : 1'($urandom % 2);
        in_data = rnd_blk();
        in_block_row = 16'($urandom);
      end else out_ready = 1'($urandom % 2);
    end
    check("rows_done", r, 2);
    in_valid = 0;
    blocks_exp++;
    @(posedge clk);
    #1;
    check("blocks_done", blocks_done, blocks_exp);
    check("sat_count", sat_count, sat_exp);
    check("idle_ready", in_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_data"}, out_data == '0, 1);
    check({tag, "_out_row"}, out_row, 0);
    check({tag, "_out_col"}, out_col, 0);
    check({tag, "_blocks_done"}, blocks_done, 0);
    check({tag, "_sat_count"}, sat_count, 0);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; in_block_row = 0; in_block_col = 0;
    scale_mult = 0; scale_shift = 0; zero_point = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 0;
    blk = '0;
    blk[0][0] = 32'd1000; blk[0][1] = 32'd12; blk[0][2] = -32'sd12;
    run_block(blk, 16'd0, 16'd0, 16'sd1, 5'd3, 8'sd0, 0);
    blk = '0;
    blk[0][0] = 32'd100000; blk[0][1] = -32'sd100000;
    run_block(blk, 16'd0, 16'd0, 16'sd1, 5'd0, 8'sd0, 0);
    run_block(rnd_blk(), 16'd5, 16'd3, 16'sd1, 5'd4, 8'sd3, 1);
    @(negedge clk);
    in_data = rnd_blk(); in_block_row = 16'd9; in_block_col = 16'd4;
    scale_mult = 16'sd1; scale_shift = 5'd0; zero_point = 8'sd0; in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_valid", out_valid, 1);
    rst = 1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 0;
    blocks_exp = 0; sat_exp = 0;
    run_block(rnd_blk(), 16'd2, 16'd7, 16'sd3, 5'd2, -8'sd5, 0);
    for (int i = 0; i < 40; i++)
      run_block(rnd_blk(), 16'($urandom_range(0, 30000)), 16'($urandom),
                ($urandom % 2) ? 16'($urandom) : 16'(int'($urandom_range(0, 20)) - 10),
                5'($urandom), 8'($urandom), ($urandom % 8) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/requant_sparse_out.md
REQUANT_SPARSE_OUT -- requirements
Module: requant_sparse_out

Interface
REQ-001 SHALL have parameters: PE_ROWS (2, rows per result block); BLOCK_W (8, columns per row); ACC_WIDTH (32, signed accumulator width); OUT_WIDTH (8, signed output width).
REQ-002 SHALL have one clock and an asynchronous, active-high reset, with these ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous active-high reset
REQ-003 SHALL have these upstream (result-side) ports:
- in_valid  in  1  result block valid
- in_data  in  PE_ROWS×BLOCK_W×ACC_WIDTH  signed INT32 partial sums, [row][col]
- in_block_row  in  16  block row index
- in_block_col  in  16  block column index
- in_ready  out  1  block accepted when high with in_valid
REQ-004 SHALL have these config ports, sampled at block accept:
- scale_mult  in  16  signed multiplier
- scale_shift  in  5  right shift, 0-31
- zero_point  in  8  signed output offset
REQ-005 SHALL have these downstream ports:
- out_valid  out  1  row valid
- out_data  out  BLOCK_W×OUT_WIDTH  signed INT8 row
- out_row  out  16  in_block_row*PE_ROWS + row index
- out_col  out  16  latched in_block_col
- out_last  out  1  final row of block
- out_ready  in  1  downstream accept
REQ-006 SHALL have these status ports:
- busy  out  1  not IDLE
- blocks_done  out  32  completed-block count
- sat_count  out  32  saturated-element count

Function
REQ-007 SHALL implement the FSM IDLE -> CALC -> EMIT; EMIT -> CALC when row_sel < PE_ROWS-1; EMIT -> IDLE after the last row.
REQ-008 In IDLE, in_ready SHALL be 1; in all other states in_ready SHALL be 0, and in_valid SHALL be ignored.
REQ-009 On in_valid&&in_ready, SHALL latch in_data, block row/col, scale_mult, scale_shift and zero_point, clear row_sel, and enter CALC.
REQ-010 In CALC (1 cycle), SHALL register BLOCK_W signed products in_data[row_sel][c]*scale_mult at ≥48 bits, no truncation.
REQ-011 In EMIT, per element, SHALL compute:
- add rounding 2^(scale_shift-1) when scale_shift>0;
- arithmetic right shift by scale_shift (round-half-up toward +inf);
- add zero_point;
- saturate to [-128,127].
REQ-012 In EMIT, out_valid SHALL be 1; out_last SHALL be 1 iff row_sel==PE_ROWS-1.
REQ-013 out_data, out_row, out_col and out_last SHALL hold stable while out_valid&&!out_ready.
REQ-014 On out_valid&&out_ready, SHALL increment row_sel or, after the last row, increment blocks_done (wrap 2^32) and enter IDLE.
REQ-015 Latency: first out_valid 2 cycles after the accept edge; minimum 2*PE_ROWS+1 cycles per block with out_ready tied high.
REQ-016 Each saturated element SHALL add 1 to sat_count once per accepted row (0-8 per handshake); sat_count SHALL saturate at 2^32-1.
REQ-017 Config port changes after accept SHALL NOT affect the in-flight block.
REQ-018 busy SHALL be 1 in CALC and EMIT.

Reset
REQ-019 rst SHALL asynchronously force state=IDLE, row_sel=0, in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0, out_row=0, out_col=0, blocks_done=0, sat_count=0.
REQ-020 rst asserted mid-block SHALL discard the in-flight block without completing it; the first accept after deassertion SHALL behave as from power-up.

Configuration
REQ-021 Macro REQUANT_RELU_EN:
- defined: after the shift and before the zero_point add, negative values SHALL be clamped to 0 (clamped values are not counted as saturated);
- undefined: no clamp, and the block is bit-exact to REQ-011.

Verification
REQ-022 acc row0=[1000,12,-12,0,...], mult=1, shift=3, zp=0 -> row0 out=[125,2,-1,0,...]; out_last=0, then 1 on row1.
REQ-023 acc=100000 and -100000, mult=1, shift=0 -> 127 and -128, sat_count +2; with REQUANT_RELU_EN, -100000 -> 0 and sat_count +1.
REQ-024 block_row=5, block_col=3 -> out_row=10 then 11, out_col=3; blocks_done 0->1 after the second handshake.
REQ-025 out_ready low 5 cycles in EMIT -> out_data/out_row stable, in_ready=0, in_valid pulses ignored, one block output total.
REQ-026 rst pulsed during EMIT of row0 -> all outputs reset per REQ-019, no out_last seen; next block emits correctly.
REQ-027 scale_mult changed 1->7 one cycle after accept -> outputs use 1.
